lc3b_skid_stage_register: RTL and testbench
===========================================

# lc3b_skid_stage_register

Parametrised pipeline stage register for the lc3b pipeline, replacing fixed per-stage latch banks with one generic block. It carries a packed payload (control word plus datapath fields) between stages using a valid/ready handshake. A two-entry skid buffer gives full throughput without a combinational path from downstream `out_ready` to upstream `in_ready`. It adds flush (bubble insertion) and a saturating stall counter.

## Interface
- `WIDTH`, 16: payload width in bits. Legal values are 1 and above; the stage packs its control word and fields into this.
- `ZERO_INVALID`, 1: when 1, `out_data` reads all-zero whenever `out_valid`=0, which makes the downstream control word a NOP. When 0, `out_data` shows the main register as-is.
- `CNT_WIDTH`, 16: width of the stall counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `reset_sig`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous discard of all held entries (branch/hazard squash)
- `in_valid`  in  1  upstream beat present
- `in_data`  in  WIDTH  upstream payload
- `in_ready`  out  1  stage can accept a beat this cycle
- `out_valid`  out  1  head entry present
- `out_data`  out  WIDTH  head entry payload
- `out_ready`  in  1  downstream consumes head this cycle
- `occupancy`  out  2  entries held (0, 1 or 2)
- `stall_count`  out  CNT_WIDTH  cycles with `out_valid`=1 and `out_ready`=0, saturating

## Operation
- Storage consists of a main register (head), a skid register, and a state in {EMPTY, ONE, TWO}.
- A beat is accepted when `in_valid` && `in_ready`. It is popped when `out_valid` && `out_ready`.
- `in_ready` = (state != TWO). It depends only on state, never on `out_ready`.
- `out_valid` = (state != EMPTY). `occupancy` is 0, 1 or 2 for EMPTY, ONE, TWO.
- Transitions from EMPTY:
  - accept: main <= `in_data`, go to ONE.
  - otherwise: stay.
- Transitions from ONE:
  - accept and pop: main <= `in_data`, stay ONE.
  - accept only: skid <= `in_data`, go to TWO.
  - pop only: go to EMPTY.
  - neither: hold.
- Transitions from TWO (no accept is possible):
  - pop: main <= skid, go to ONE.
  - no pop: hold.
- Ordering is strictly FIFO. The skid entry never overtakes the main entry.
- Priority is `reset_sig` > `flush` > normal operation.
- `reset_sig`: state goes to EMPTY, main, skid and `stall_count` are zeroed.
- `flush`: state goes to EMPTY and main and skid are zeroed.
  - Any beat presented in the flush cycle is dropped, even if `in_ready`=1.
  - Any pop in the flush cycle still completes from the downstream view, since `out_data` was valid that cycle.
  - `stall_count` is not affected.
- `stall_count` increments by 1 in each cycle where `out_valid` && !`out_ready` && !`reset_sig`. It holds at 2^CNT_WIDTH-1.
- Freed entries are not cleared. With `ZERO_INVALID`=1 the output mask hides stale data.

## Timing
- Reset values:
  - `in_ready`=1, `out_valid`=0, `occupancy`=0, `stall_count`=0.
  - `out_data`=0.
  - These hold in the cycle after `reset_sig` is sampled high.
- Latency: a beat accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput is 1 beat/cycle sustained when `out_ready`=1.
- Stall and buffering:
  - When downstream deasserts `out_ready`, one extra beat is absorbed by the skid register.
  - `in_ready` drops in the cycle after that absorption.
- All outputs are register-driven. The only logic on them is the `ZERO_INVALID` AND mask on `out_data`.
- Simultaneous `flush` and `reset_sig` behave as reset.
- Reset mid-transfer: the TWO state is lost and no beat is emitted afterwards.

## Test plan
- Streaming:
  - Stimulus: reset, then `in_valid`=1 with `in_data` 0x0001..0x0008 on consecutive cycles, `out_ready`=1.
  - Response: `out_data` shows 0x0001..0x0008 one cycle later with no gaps; `occupancy` stays 1; `stall_count`=0.
- Skid fill:
  - Stimulus: stream 0x00A1, 0x00A2, 0x00A3 while `out_ready`=0 from the second cycle on.
  - Response: `occupancy` goes 1 then 2. `in_ready`=0 while the state is TWO, and 0x00A3 is held upstream. Release `out_ready`: outputs are 0xA1, 0xA2, 0xA3 in order.
- Flush:
  - Stimulus: state TWO holding 0x0011 and 0x0022; assert `flush` with `in_valid`=1 and `in_data`=0x0033.
  - Response: next cycle `out_valid`=0, `out_data`=0, `occupancy`=0. 0x0033 is never emitted. `stall_count` is unchanged.
- Stall counter saturation:
  - Stimulus: CNT_WIDTH=3, hold one entry with `out_ready`=0 for 10 cycles.
  - Response: `stall_count` reads 7 and stays 7. Assert `reset_sig`: `stall_count`=0.
- ZERO_INVALID:
  - Stimulus: with `ZERO_INVALID`=0, push 0xBEEF then pop.
  - Response: `out_valid`=0 and `out_data` remains 0xBEEF. With `ZERO_INVALID`=1 the same sequence gives `out_data`=0x0000.
- Reset mid-operation:
  - Stimulus: in state TWO, assert `reset_sig` together with `flush` and `in_valid`.
  - Response: all reset values next cycle; the next accepted beat emerges with 1-cycle latency.

Source files
------------

// File: rtl/lc3b_skid_stage_register.sv
// Generic lc3b pipeline stage register: valid/ready handshake with a two-entry
// skid buffer, flush (bubble insertion) and a saturating stall counter.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | head entry in main register
// TWO   | head in main, next entry in skid, upstream held off
module lc3b_skid_stage_register #(
    parameter int WIDTH        = 16,
    parameter bit ZERO_INVALID = 1'b1,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset_sig,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 out_ready,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     main_q, main_nxt;
    logic [WIDTH-1:0]     skid_q, skid_nxt;
    logic [CNT_WIDTH-1:0] stall_q, stall_nxt;
    logic                 accept, pop;

    // Encoding chosen so the state register doubles as the occupancy count.
    assign occupancy   = state;
    assign in_ready    = (state != TWO);
    assign out_valid   = (state != EMPTY);
    assign out_data    = (ZERO_INVALID && !out_valid) ? '0 : main_q;
    assign stall_count = stall_q;

    assign accept = in_valid && in_ready;
    assign pop    = out_valid && out_ready;

    always_comb begin
        state_nxt = state;
        main_nxt  = main_q;
        skid_nxt  = skid_q;
        stall_nxt = stall_q;

        case (state)
            EMPTY: begin
                if (accept) begin
                    main_nxt  = in_data;
                    state_nxt = ONE;
                end
            end
            ONE: begin
                if (accept && pop) begin
                    main_nxt = in_data;
                end else if (accept) begin
                    skid_nxt  = in_data;
                    state_nxt = TWO;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    main_nxt  = skid_q;
                    state_nxt = ONE;
                end
            end
            default: state_nxt = EMPTY;
        endcase

        // Flush drops the incoming beat too; a pop this cycle already completed downstream.
        if (flush) begin
            state_nxt = EMPTY;
            main_nxt  = '0;
            skid_nxt  = '0;
        end

        if (out_valid && !out_ready && (stall_q != {CNT_WIDTH{1'b1}})) begin
            stall_nxt = stall_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_sig) begin
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state   <= state_nxt;
            main_q  <= main_nxt;
            skid_q  <= skid_nxt;
            stall_q <= stall_nxt;
        end
    end

endmodule

// File: tb/tb_lc3b_skid_stage_register.sv
// Self-checking bench for lc3b_skid_stage_register: scenario tasks plus a
// queue scoreboard that tracks accepted beats and checks every pop in order.
module tb_lc3b_skid_stage_register;

    logic        clk = 1'b0;
    logic        reset_sig, flush, in_valid, out_ready;
    logic [15:0] in_data;

    logic        in_ready_m, out_valid_m, in_ready_c, out_valid_c, in_ready_z, out_valid_z;
    logic [15:0] out_data_m, out_data_c, out_data_z;
    logic [1:0]  occ_m, occ_c, occ_z;
    logic [15:0] stall_m, stall_z;
    logic [2:0]  stall_c;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [15:0] sb_q[$];

    always #5 clk = ~clk;

    lc3b_skid_stage_register #(.WIDTH(16), .ZERO_INVALID(1'b1), .CNT_WIDTH(16)) dut_m (
        .clk(clk), .reset_sig(reset_sig), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_m), .out_valid(out_valid_m), .out_data(out_data_m), .out_ready(out_ready),
        .occupancy(occ_m), .stall_count(stall_m));

    lc3b_skid_stage_register #(.WIDTH(16), .ZERO_INVALID(1'b1), .CNT_WIDTH(3)) dut_c (
        .clk(clk), .reset_sig(reset_sig), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_c), .out_valid(out_valid_c), .out_data(out_data_c), .out_ready(out_ready),
        .occupancy(occ_c), .stall_count(stall_c));

    lc3b_skid_stage_register #(.WIDTH(16), .ZERO_INVALID(1'b0), .CNT_WIDTH(16)) dut_z (
        .clk(clk), .reset_sig(reset_sig), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_z), .out_valid(out_valid_z), .out_data(out_data_z), .out_ready(out_ready),
        .occupancy(occ_z), .stall_count(stall_z));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Samples at the falling edge: state after the last rising edge, and the
    // handshake about to be taken at the next one.
    task automatic run_monitor();
        logic [15:0] exp;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                checks++;
                if (occ_m !== 2'(sb_q.size()) || in_ready_m !== (sb_q.size() != 2)) begin
                    errors++;
                    $display("FAIL sb_occupancy: got occ=%0d in_ready=%b, want occ=%0d", occ_m, in_ready_m, sb_q.size());
                end
                if (!reset_sig && out_valid_m && out_ready) begin
                    checks++;
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_pop_empty: got 0x%04h popped, want no beat", out_data_m);
                    end else begin
                        exp = sb_q.pop_front();
                        if (out_data_m !== exp) begin
                            errors++;
                            $display("FAIL sb_order: got 0x%04h, want 0x%04h", out_data_m, exp);
                        end
                    end
                end
                if (reset_sig || flush) sb_q.delete();
                else if (in_valid && in_ready_m) sb_q.push_back(in_data);
            end
        end
    endtask

    task automatic test_reset();
        reset_sig = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        tick(); tick();
        checks++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || occ_m !== 2'd0 || stall_m !== 16'd0 || out_data_m !== 16'd0) begin
            errors++;
            $display("FAIL reset_values: got rdy=%b vld=%b occ=%0d stall=%0d data=0x%04h, want 1 0 0 0 0x0000",
                     in_ready_m, out_valid_m, occ_m, stall_m, out_data_m);
        end
        reset_sig = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = 16'(i);
            tick();
            checks++;
            if (out_valid_m !== 1'b1 || out_data_m !== 16'(i) || occ_m !== 2'd1 || stall_m !== 16'd0) begin
                errors++;
                $display("FAIL stream_%0d: got vld=%b data=0x%04h occ=%0d stall=%0d, want 1 0x%04h 1 0",
                         i, out_valid_m, out_data_m, occ_m, stall_m, i);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid_m !== 1'b0 || occ_m !== 2'd0) begin
            errors++;
            $display("FAIL stream_drain: got vld=%b occ=%0d, want 0 0", out_valid_m, occ_m);
        end
    endtask

    task automatic test_skid_fill();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h00A1;
        tick();
        checks++;
        if (occ_m !== 2'd1) begin errors++; $display("FAIL skid_occ1: got %0d, want 1", occ_m); end
        out_ready = 1'b0; in_data = 16'h00A2;
        tick();
        checks++;
        if (occ_m !== 2'd2 || in_ready_m !== 1'b0) begin
            errors++;
            $display("FAIL skid_occ2: got occ=%0d rdy=%b, want 2 0", occ_m, in_ready_m);
        end
        in_data = 16'h00A3;
        tick();
        checks++;
        if (occ_m !== 2'd2 || in_ready_m !== 1'b0 || out_data_m !== 16'h00A1 || stall_m !== 16'd2) begin
            errors++;
            $display("FAIL skid_hold: got occ=%0d rdy=%b data=0x%04h stall=%0d, want 2 0 0x00a1 2",
                     occ_m, in_ready_m, out_data_m, stall_m);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_data_m !== 16'h00A2 || occ_m !== 2'd1) begin
            errors++;
            $display("FAIL skid_release1: got data=0x%04h occ=%0d, want 0x00a2 1", out_data_m, occ_m);
        end
        tick();
        checks++;
        if (out_data_m !== 16'h00A3 || occ_m !== 2'd1) begin
            errors++;
            $display("FAIL skid_release2: got data=0x%04h occ=%0d, want 0x00a3 1", out_data_m, occ_m);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        logic [15:0] stall_before;
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0011;
        tick();
        in_data = 16'h0022;
        tick();
        stall_before = stall_m;
        flush = 1'b1; out_ready = 1'b1; in_data = 16'h0033;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid_m !== 1'b0 || out_data_m !== 16'h0000 || occ_m !== 2'd0 || stall_m !== stall_before) begin
            errors++;
            $display("FAIL flush: got vld=%b data=0x%04h occ=%0d stall=%0d, want 0 0x0000 0 %0d",
                     out_valid_m, out_data_m, occ_m, stall_m, stall_before);
        end
        checks++;
        if (out_data_z !== 16'h0000) begin
            errors++;
            $display("FAIL flush_zeroes_main: got 0x%04h, want 0x0000", out_data_z);
        end
        tick(); tick();
        checks++;
        if (out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL flush_no_emit: got vld=%b, want 0", out_valid_m);
        end
    endtask

    task automatic test_stall_saturation();
        reset_sig = 1'b1;
        tick();
        reset_sig = 1'b0; out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0042;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 7 || k == 10) begin
                checks++;
                if (stall_c !== 3'd7 || stall_m !== 16'(k)) begin
                    errors++;
                    $display("FAIL stall_sat_%0d: got c3=%0d c16=%0d, want 7 %0d", k, stall_c, stall_m, k);
                end
            end
        end
        reset_sig = 1'b1;
        tick();
        reset_sig = 1'b0;
        checks++;
        if (stall_c !== 3'd0 || stall_m !== 16'd0) begin
            errors++;
            $display("FAIL stall_reset: got c3=%0d c16=%0d, want 0 0", stall_c, stall_m);
        end
    endtask

    task automatic test_zero_invalid();
        out_ready = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid_z !== 1'b0 || out_data_z !== 16'hBEEF) begin
            errors++;
            $display("FAIL zi0_stale: got vld=%b data=0x%04h, want 0 0xbeef", out_valid_z, out_data_z);
        end
        checks++;
        if (out_valid_m !== 1'b0 || out_data_m !== 16'h0000) begin
            errors++;
            $display("FAIL zi1_mask: got vld=%b data=0x%04h, want 0 0x0000", out_valid_m, out_data_m);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h0055;
        tick();
        in_data = 16'h0066;
        tick();
        reset_sig = 1'b1; flush = 1'b1; in_data = 16'h0077;
        tick();
        checks++;
        if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || occ_m !== 2'd0 || stall_m !== 16'd0 || out_data_m !== 16'd0
            || out_data_z !== 16'd0) begin
            errors++;
            $display("FAIL reset_mid: got rdy=%b vld=%b occ=%0d stall=%0d data=0x%04h, want 1 0 0 0 0x0000",
                     in_ready_m, out_valid_m, occ_m, stall_m, out_data_m);
        end
        reset_sig = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick();
        checks++;
        if (out_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_emit: got vld=%b, want 0", out_valid_m);
        end
        in_valid = 1'b1; in_data = 16'h0088;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid_m !== 1'b1 || out_data_m !== 16'h0088) begin
            errors++;
            $display("FAIL reset_mid_latency: got vld=%b data=0x%04h, want 1 0x0088", out_valid_m, out_data_m);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 300; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            in_data   = 16'($urandom);
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (out_valid_m !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain: got vld=%b pending=%0d, want 0 0", out_valid_m, sb_q.size());
        end
    endtask

    initial begin
        fork
            run_monitor();
        join_none
        test_reset();
        test_streaming();
        test_skid_fill();
        test_flush();
        test_stall_saturation();
        test_zero_invalid();
        test_reset_mid();
        test_back_to_back();
        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
